muxb_arbiter: RTL and testbench
===============================

MUXB_ARBITER -- requirements
Module: muxb_arbiter

Interface
REQ-001 Parameter: WIDTH, default 16, operand data width.
REQ-002 Ports (clock and reset first):
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req1  input  1  requester 1 wants to place in1 on operand bus B.
- in1  input  WIDTH  requester 1 operand.
- req2  input  1  requester 2 wants to place in2 on operand bus B.
- in2  input  WIDTH  requester 2 operand.
- ready  input  1  downstream consumer accepts outB this cycle.
- sel  output  1  muxB select; 0 = in1, 1 = in2; registered.
- valid  output  1  outB holds a granted operand; registered.
- outB  output  WIDTH  captured operand; registered.
- ack1  output  1  combinational, = valid & ready & (sel==0).
- ack2  output  1  combinational, = valid & ready & (sel==1).
- xfer_count  output  16  completed-transfer counter; registered.
REQ-003 The block SHALL have one clock (clk); reset (rst) SHALL be asynchronous and active-high.

Function
REQ-004 States SHALL be IDLE (valid=0) and HOLD (valid=1); encoding is local to the block.
REQ-005 IDLE: on a rising edge with req1|req2 high, the block SHALL select a winner, load sel, capture the winner's operand into outB, set valid and enter HOLD. Latency is 1 cycle from the sampled request to valid.
REQ-006 Arbitration SHALL be round-robin using a 1-bit pointer last_served. When both requests are high, the requester not equal to last_served SHALL win.
REQ-007 A lone request SHALL win regardless of the pointer.
REQ-008 HOLD: sel, outB and valid SHALL remain stable until a rising edge with ready=1 (completion edge). Changes on inX/reqX during HOLD SHALL NOT affect outB.
REQ-009 On the completion edge:
- last_served SHALL be set to the current owner.
- xfer_count SHALL increment by 1 and wrap from 16'hFFFF to 16'h0000.
- The just-served requester's req SHALL be masked for that edge only.
REQ-010 Completion edge, next grant: if the other requester's req is high, the block SHALL grant it back-to-back (new sel/outB, valid stays 1, no bubble). Otherwise it SHALL return to IDLE with valid=0.
REQ-011 A requester SHALL hold reqX and inX stable until it sees ackX high at a rising edge; deasserting req in HOLD SHALL NOT cancel the transfer already captured.
REQ-012 ready while in IDLE SHALL be ignored; ack1 and ack2 SHALL never be high together.
REQ-013 outB SHALL retain its last value in IDLE (no clearing).

Reset
REQ-014 While rst=1, independent of clk:
- state = IDLE, valid = 0, sel = 0.
- outB = 0, xfer_count = 0.
- last_served = 1, so requester 1 wins the first contended arbitration.
REQ-015 Reset asserted in HOLD SHALL abort the transfer with no ack and no count increment.
REQ-016 The first arbitration SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-017 The shared CPU package SHALL hold the WIDTH default (16), the SEL_IN1=0 / SEL_IN2=1 constants and the arbiter state typedef.
REQ-018 The block SHALL be a single module with no sub-modules; muxB is instantiated beside it at the datapath level, with sel driven from this block.

Verification
REQ-019 rst high, then in IDLE set req1=1, in1=16'h0001 -> after 1 edge: valid=1, sel=0, outB=16'h0001; ready=1 -> ack1=1; xfer_count=1.
REQ-020 After reset, req1=req2=1 (in1=16'h0010, in2=16'h0011), ready=1 continuously -> outB sequence 0010, 0011, 0010, ... alternating every cycle with no bubble, and ack1/ack2 alternating.
REQ-021 Grant to req2 with ready=0 for 5 cycles while in2 changes to 16'hFFFF -> outB stays at the captured value and valid=1 throughout; completes on the first ready=1 edge.
REQ-022 Preload xfer_count to 16'hFFFF via 65535 transfers, then one more transfer -> xfer_count=16'h0000.
REQ-023 Assert rst mid-HOLD -> valid=0, outB=0 and xfer_count=0 immediately (asynchronous), with no ack pulse.
REQ-024 Only req2 held high through its own completion edge -> the masked edge returns to IDLE (valid=0 for 1 cycle), then re-grant to req2 on the next edge.

Source files
------------

// File: rtl/muxb_arbiter_pkg.sv
// Shared definitions for the operand-bus B arbiter: widths, muxB select codes,
// state type and the round-robin pick rule.
package muxb_arbiter_pkg;

   localparam int unsigned MUXB_WIDTH = 16;
   localparam int unsigned XFER_CNT_W = 16;

   localparam logic SEL_IN1 = 1'b0;
   localparam logic SEL_IN2 = 1'b1;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

   // Winner as a muxB select code; last is the select code served most recently.
   function automatic logic arb_pick(input logic r1, input logic r2, input logic last);
      if (r1 && r2) begin
         return ~last;
      end else if (r2) begin
         return SEL_IN2;
      end else begin
         return SEL_IN1;
      end
   endfunction

endpackage

// File: rtl/muxb_arbiter.sv
// Two-requester round-robin arbiter for operand bus B: captures the winning
// operand, holds it until the consumer accepts, and counts completed transfers.
module muxb_arbiter
   import muxb_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = MUXB_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req1,
   input  logic [WIDTH-1:0]      in1,
   input  logic                  req2,
   input  logic [WIDTH-1:0]      in2,
   input  logic                  ready,
   output logic                  sel,
   output logic                  valid,
   output logic [WIDTH-1:0]      outB,
   output logic                  ack1,
   output logic                  ack2,
   output logic [XFER_CNT_W-1:0] xfer_count
);

   arb_state_t       state;
   logic             last_served;
   logic             req1_eff;
   logic             req2_eff;
   logic             win;
   logic [WIDTH-1:0] win_data;

   // In HOLD the current owner is masked, so a completion edge can only hand over to the other side.
   always_comb begin
      req1_eff = req1;
      req2_eff = req2;
      if (state == ARB_HOLD) begin
         req1_eff = req1 & (sel != SEL_IN1);
         req2_eff = req2 & (sel != SEL_IN2);
      end
      win      = arb_pick(req1_eff, req2_eff, last_served);
      win_data = (win == SEL_IN2) ? in2 : in1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ARB_IDLE;
         valid       <= 1'b0;
         sel         <= SEL_IN1;
         outB        <= '0;
         xfer_count  <= '0;
         last_served <= SEL_IN2;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (req1_eff || req2_eff) begin
                  sel   <= win;
                  outB  <= win_data;
                  valid <= 1'b1;
                  state <= ARB_HOLD;
               end
            end
            ARB_HOLD: begin
               if (ready) begin
                  last_served <= sel;
                  xfer_count  <= XFER_CNT_W'(xfer_count + 1'b1);
                  if (req1_eff || req2_eff) begin
                     sel  <= win;
                     outB <= win_data;
                  end else begin
                     valid <= 1'b0;
                     state <= ARB_IDLE;
                  end
               end
            end
            default: begin
               valid <= 1'b0;
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   assign ack1 = valid & ready & (sel == SEL_IN1);
   assign ack2 = valid & ready & (sel == SEL_IN2);

endmodule

// File: tb/tb_muxb_arbiter.sv
// Bench for muxb_arbiter: directed scenarios against fixed values plus a
// randomized protocol-respecting run against a transaction-level model.
module tb_muxb_arbiter;

   logic        clk;
   logic        rst;
   logic        req1;
   logic [15:0] in1;
   logic        req2;
   logic [15:0] in2;
   logic        ready;
   logic        sel;
   logic        valid;
   logic [15:0] outB;
   logic        ack1;
   logic        ack2;
   logic [15:0] xfer_count;

   int tests;
   int fails;

   // Transaction-level model: who owns the bus, what it carries, and history.
   bit          m_busy;
   bit          m_owner;
   bit          m_last;
   logic [15:0] m_out;
   logic [15:0] m_count;
   bit          m_served;
   bit          m_served_who;

   muxb_arbiter #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req1       (req1),
      .in1        (in1),
      .req2       (req2),
      .in2        (in2),
      .ready      (ready),
      .sel        (sel),
      .valid      (valid),
      .outB       (outB),
      .ack1       (ack1),
      .ack2       (ack2),
      .xfer_count (xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_busy   = 0;
      m_owner  = 0;
      m_last   = 1;
      m_out    = 16'h0000;
      m_count  = 16'h0000;
      m_served = 0;
   endtask

   // One rising edge: the bus is released if accepted, then offered to eligible requesters.
   task automatic tick();
      bit c1, c2, free;
      @(posedge clk);
      c1 = req1;
      c2 = req2;
      free = !m_busy;
      m_served = 0;
      if (m_busy && ready) begin
         m_count      = m_count + 16'd1;
         m_last       = m_owner;
         m_served     = 1;
         m_served_who = m_owner;
         if (m_owner) c2 = 0; else c1 = 0;
         m_busy = 0;
         free   = 1;
      end
      if (free && (c1 || c2)) begin
         if (c1 && c2) m_owner = !m_last;
         else          m_owner = c2;
         m_out  = m_owner ? in2 : in1;
         m_busy = 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      req1  = 1'b0;
      req2  = 1'b0;
      in1   = 16'h0000;
      in2   = 16'h0000;
      ready = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (valid !== 1'b0)       begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
      tests++; if (sel !== 1'b0)         begin fails++; $display("FAIL reset_sel: got %b expected 0", sel); end
      tests++; if (outB !== 16'h0000)    begin fails++; $display("FAIL reset_outB: got %h expected 0000", outB); end
      tests++; if (xfer_count !== 16'h0) begin fails++; $display("FAIL reset_count: got %h expected 0000", xfer_count); end
      tests++; if ((ack1 | ack2) !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b%b expected 00", ack1, ack2); end
   endtask

   task automatic test_single();
      do_reset();
      ready = 1'b1;
      tick(); #1;
      tests++; if (valid !== 1'b0 || xfer_count !== 16'h0) begin fails++; $display("FAIL idle_ready_ignored: got valid=%b count=%h expected 0/0000", valid, xfer_count); end
      ready = 1'b0; req1 = 1'b1; in1 = 16'h0001;
      tick(); #1;
      tests++; if (valid !== 1'b1)       begin fails++; $display("FAIL single_valid: got %b expected 1", valid); end
      tests++; if (sel !== 1'b0)         begin fails++; $display("FAIL single_sel: got %b expected 0", sel); end
      tests++; if (outB !== 16'h0001)    begin fails++; $display("FAIL single_outB: got %h expected 0001", outB); end
      ready = 1'b1; #1;
      tests++; if (ack1 !== 1'b1 || ack2 !== 1'b0) begin fails++; $display("FAIL single_ack: got %b%b expected 10", ack1, ack2); end
      tick();
      req1 = 1'b0; ready = 1'b0; #1;
      tests++; if (xfer_count !== 16'h0001) begin fails++; $display("FAIL single_count: got %h expected 0001", xfer_count); end
      tests++; if (valid !== 1'b0)          begin fails++; $display("FAIL single_idle: got %b expected 0", valid); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      do_reset();
      req1 = 1'b1; in1 = 16'h0010;
      req2 = 1'b1; in2 = 16'h0011;
      ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick(); #1;
         exp = (k % 2 == 0) ? 16'h0010 : 16'h0011;
         tests++; if (valid !== 1'b1 || outB !== exp) begin fails++; $display("FAIL b2b_outB[%0d]: got valid=%b outB=%h expected 1/%h", k, valid, outB, exp); end
         tests++; if (ack1 !== (k % 2 == 0) || ack2 !== (k % 2 == 1)) begin fails++; $display("FAIL b2b_ack[%0d]: got %b%b expected %b%b", k, ack1, ack2, (k % 2 == 0), (k % 2 == 1)); end
      end
      tests++; if (xfer_count !== 16'd7) begin fails++; $display("FAIL b2b_count: got %0d expected 7", xfer_count); end
      req1 = 1'b0; req2 = 1'b0; ready = 1'b0;
   endtask

   task automatic test_hold_stall();
      do_reset();
      req2 = 1'b1; in2 = 16'h1234;
      tick(); #1;
      tests++; if (valid !== 1'b1 || sel !== 1'b1 || outB !== 16'h1234) begin fails++; $display("FAIL stall_grant: got v=%b s=%b o=%h expected 1/1/1234", valid, sel, outB); end
      in2 = 16'hFFFF;
      for (int k = 0; k < 5; k++) begin
         tick(); #1;
         tests++; if (valid !== 1'b1 || outB !== 16'h1234 || ack2 !== 1'b0) begin fails++; $display("FAIL stall_hold[%0d]: got v=%b o=%h a=%b expected 1/1234/0", k, valid, outB, ack2); end
      end
      ready = 1'b1; #1;
      tests++; if (ack2 !== 1'b1 || ack1 !== 1'b0) begin fails++; $display("FAIL stall_ack: got %b%b expected 01", ack1, ack2); end
      tick();
      req2 = 1'b0; ready = 1'b0; #1;
      tests++; if (valid !== 1'b0 || xfer_count !== 16'h0001) begin fails++; $display("FAIL stall_done: got v=%b c=%h expected 0/0001", valid, xfer_count); end
      tests++; if (outB !== 16'h1234) begin fails++; $display("FAIL idle_retain: got %h expected 1234", outB); end
   endtask

   task automatic test_masked_reissue();
      do_reset();
      req2 = 1'b1; in2 = 16'h00AB; ready = 1'b1;
      tick(); #1;
      tests++; if (valid !== 1'b1 || sel !== 1'b1) begin fails++; $display("FAIL mask_grant: got v=%b s=%b expected 1/1", valid, sel); end
      tick(); #1;
      tests++; if (valid !== 1'b0 || xfer_count !== 16'h0001) begin fails++; $display("FAIL mask_bubble: got v=%b c=%h expected 0/0001", valid, xfer_count); end
      tick(); #1;
      tests++; if (valid !== 1'b1 || sel !== 1'b1 || outB !== 16'h00AB) begin fails++; $display("FAIL mask_regrant: got v=%b s=%b o=%h expected 1/1/00ab", valid, sel, outB); end
      req2 = 1'b0;
      tick(); #1;
      tests++; if (valid !== 1'b0 || xfer_count !== 16'h0002) begin fails++; $display("FAIL mask_done: got v=%b c=%h expected 0/0002", valid, xfer_count); end
      ready = 1'b0;
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      req1 = 1'b1; in1 = 16'h5A5A; ready = 1'b1;
      tick();
      tick();
      ready = 1'b0;
      tick(); #1;
      tests++; if (valid !== 1'b1 || xfer_count !== 16'h0001 || outB !== 16'h5A5A) begin fails++; $display("FAIL rsthold_setup: got v=%b c=%h o=%h expected 1/0001/5a5a", valid, xfer_count, outB); end
      rst = 1'b1; #1;
      tests++; if (valid !== 1'b0 || outB !== 16'h0000 || xfer_count !== 16'h0000) begin fails++; $display("FAIL rsthold_async: got v=%b o=%h c=%h expected 0/0000/0000", valid, outB, xfer_count); end
      ready = 1'b1; #1;
      tests++; if (ack1 !== 1'b0 || ack2 !== 1'b0) begin fails++; $display("FAIL rsthold_noack: got %b%b expected 00", ack1, ack2); end
      do_reset();
   endtask

   task automatic test_wrap();
      int n;
      do_reset();
      req1 = 1'b1; in1 = 16'h0A0A;
      req2 = 1'b1; in2 = 16'h0B0B;
      ready = 1'b1;
      n = 0;
      while (m_count != 16'hFFFF && n < 70000) begin
         tick();
         n++;
      end
      #1;
      tests++; if (xfer_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h expected ffff after %0d edges", xfer_count, n); end
      tick(); #1;
      tests++; if (xfer_count !== 16'h0000) begin fails++; $display("FAIL wrap_zero: got %h expected 0000", xfer_count); end
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL wrap_valid: got %b expected 1", valid); end
      req1 = 1'b0; req2 = 1'b0; ready = 1'b0;
   endtask

   // Requesters follow the handshake: raise with data, hold both until their ack edge.
   task automatic test_random();
      bit pend1, pend2;
      do_reset();
      pend1 = 0;
      pend2 = 0;
      for (int k = 0; k < 3000; k++) begin
         if (m_served && !m_served_who) pend1 = 0;
         if (m_served &&  m_served_who) pend2 = 0;
         if (!pend1 && ($urandom % 3 == 0)) begin pend1 = 1; in1 = 16'($urandom); end
         if (!pend2 && ($urandom % 3 == 0)) begin pend2 = 1; in2 = 16'($urandom); end
         req1  = pend1;
         req2  = pend2;
         ready = ($urandom % 4 != 0);
         #1;
         tests++; if (valid !== m_busy) begin fails++; $display("FAIL rand_valid[%0d]: got %b expected %b", k, valid, m_busy); end
         tests++; if (outB !== m_out)   begin fails++; $display("FAIL rand_outB[%0d]: got %h expected %h", k, outB, m_out); end
         if (m_busy) begin
            tests++; if (sel !== m_owner) begin fails++; $display("FAIL rand_sel[%0d]: got %b expected %b", k, sel, m_owner); end
         end
         tests++; if (xfer_count !== m_count) begin fails++; $display("FAIL rand_count[%0d]: got %h expected %h", k, xfer_count, m_count); end
         tests++; if (ack1 !== (m_busy && ready && !m_owner)) begin fails++; $display("FAIL rand_ack1[%0d]: got %b expected %b", k, ack1, (m_busy && ready && !m_owner)); end
         tests++; if (ack2 !== (m_busy && ready && m_owner))  begin fails++; $display("FAIL rand_ack2[%0d]: got %b expected %b", k, ack2, (m_busy && ready && m_owner)); end
         tick();
      end
      req1 = 1'b0; req2 = 1'b0; ready = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_hold_stall();
      test_masked_reissue();
      test_reset_mid_hold();
      test_random();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
